// File: rtl/tone_pkg.sv
// Shared parameters, envelope state type and the sine table generator for tone_synth.
package tone_pkg;

  localparam int PHASE_W  = 16;
  localparam int LUT_AW   = 10;
  localparam int SAMPLE_W = 16;
  localparam int VOL_W    = 7;
  localparam int ENV_STEP = 1;
  localparam int SINE_AMP = 32767;
  localparam string ROM_FILE = "sin.txt";

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

  // round(SINE_AMP*sin(2*pi*k/2^LUT_AW)), built from a first-quadrant Taylor series
  // so the table comes out of elaboration instead of an external file.
  function automatic logic signed [SAMPLE_W-1:0] sine_entry(input int k);
    int  n_half;
    int  i;
    real x;
    real term;
    real s;
    n_half = (2 ** LUT_AW) / 2;
    i = k % n_half;
    if (i > n_half / 2) i = n_half - i;
    x = 6.283185307179586 * $itor(i) / $itor(2 ** LUT_AW);
    term = x;
    s = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / $itor((2 * n) * (2 * n + 1));
      s = s + term;
    end
    i = $rtoi($itor(SINE_AMP) * s + 0.5);
    return (k >= n_half) ? SAMPLE_W'(-i) : SAMPLE_W'(i);
  endfunction

endpackage

// File: rtl/sine_rom.sv
// Full-wave sine ROM with a registered read port (one cycle latency).
module sine_rom
  import tone_pkg::*;
(
  input  logic                       clk,
  input  logic [LUT_AW-1:0]          addr,
  output logic signed [SAMPLE_W-1:0] data
);

  logic signed [SAMPLE_W-1:0] rom [2**LUT_AW];
  logic signed [SAMPLE_W-1:0] data_d;
  logic signed [SAMPLE_W-1:0] data_q;

  for (genvar k = 0; k < 2**LUT_AW; k++) begin : g_rom
    localparam logic signed [SAMPLE_W-1:0] VAL = sine_entry(k);
    assign rom[k] = VAL;
  end

  always_comb begin
    data_d = rom[addr];
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign data = data_q;

endmodule

// File: rtl/tone_synth.sv
// Phase accumulator -> sine ROM -> gain scaler, one sample per sample_req, 3-cycle latency.
// Optional attack/release envelope enabled with `define TONE_ENVELOPE_EN.
module tone_synth
  import tone_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PHASE_W-1:0]         freq,
  input  logic [VOL_W-1:0]           volume,
  input  logic                       sample_req,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_valid,
  output logic                       active
);

  logic [PHASE_W-1:0]         phase_d, phase_q;
  logic [LUT_AW-1:0]          rom_addr_d, rom_addr_q;
  logic [VOL_W-1:0]           gain0_d, gain0_q, gain1_d, gain1_q;
  logic                       v0_d, v0_q, v1_d, v1_q, v2_d, v2_q;
  logic                       active_d, active_q;
  logic signed [SAMPLE_W-1:0] sample_d, sample_q;
  logic signed [SAMPLE_W-1:0] sine;
  logic signed [SAMPLE_W+VOL_W:0] prod;
`ifdef TONE_ENVELOPE_EN
  env_state_t                 env_d, env_q;
  logic [VOL_W-1:0]           gain_d, gain_q, gain_up, gain_dn;
  logic [PHASE_W-1:0]         inc_d, inc_q;
`endif

  sine_rom u_rom (
    .clk  (clk),
    .addr (rom_addr_q),
    .data (sine)
  );

  assign prod = sine * $signed({1'b0, gain1_q});

`ifdef TONE_ENVELOPE_EN
  assign gain_up = (gain_q >= volume) ? volume : gain_q + VOL_W'(ENV_STEP);
  assign gain_dn = (gain_q > VOL_W'(ENV_STEP)) ? gain_q - VOL_W'(ENV_STEP) : '0;
`endif

  always_comb begin
    phase_d    = phase_q;
    rom_addr_d = rom_addr_q;
    gain0_d    = gain0_q;
    active_d   = active_q;
    v0_d       = sample_req;
    v1_d       = v0_q;
    gain1_d    = gain0_q;
    v2_d       = v1_q;
    sample_d   = v1_q ? SAMPLE_W'(prod >>> VOL_W) : sample_q;
`ifdef TONE_ENVELOPE_EN
    env_d  = env_q;
    gain_d = gain_q;
    inc_d  = inc_q;
`endif
    if (sample_req) begin
      rom_addr_d = phase_q[PHASE_W-1 -: LUT_AW];
`ifdef TONE_ENVELOPE_EN
      // Release keeps stepping with the last nonzero increment until gain reaches 0.
      if (freq != '0) begin
        inc_d = freq;
        if (env_q == SUSTAIN) begin
          gain_d = volume;
        end else begin
          gain_d = gain_up;
          env_d  = (gain_up == volume) ? SUSTAIN : ATTACK;
        end
      end else if (env_q != IDLE) begin
        gain_d = gain_dn;
        env_d  = (gain_dn == '0) ? IDLE : RELEASE;
      end else begin
        gain_d = '0;
      end
      gain0_d  = gain_d;
      active_d = (gain_d != '0);
      phase_d  = (env_d == IDLE) ? '0 : phase_q + inc_d;
`else
      gain0_d  = (freq == '0) ? '0 : volume;
      active_d = (freq != '0);
      phase_d  = (freq == '0) ? '0 : phase_q + freq;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      rom_addr_q <= '0;
      gain0_q    <= '0;
      gain1_q    <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      active_q   <= 1'b0;
      sample_q   <= '0;
`ifdef TONE_ENVELOPE_EN
      env_q      <= IDLE;
      gain_q     <= '0;
      inc_q      <= '0;
`endif
    end else begin
      phase_q    <= phase_d;
      rom_addr_q <= rom_addr_d;
      gain0_q    <= gain0_d;
      gain1_q    <= gain1_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      active_q   <= active_d;
      sample_q   <= sample_d;
`ifdef TONE_ENVELOPE_EN
      env_q      <= env_d;
      gain_q     <= gain_d;
      inc_q      <= inc_d;
`endif
    end
  end

  assign sample       = sample_q;
  assign sample_valid = v2_q;
  assign active       = active_q;

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth: reset, latency, gain scaling, wrap, silence and mid-pipeline reset.
module tb_tone_synth;

  logic               clk = 1'b0;
  logic               rst;
  logic [15:0]        freq;
  logic [6:0]         volume;
  logic               sample_req;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic               active;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  tone_synth dut (
    .clk          (clk),
    .rst          (rst),
    .freq         (freq),
    .volume       (volume),
    .sample_req   (sample_req),
    .sample       (sample),
    .sample_valid (sample_valid),
    .active       (active)
  );

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request, then verify the pulse lands exactly 3 cycles later and the sample holds.
  task automatic req_check(input string tag, input logic [15:0] f, input logic [6:0] v,
                           input logic signed [15:0] e, input logic [6:0] v_after);
    freq = f;
    volume = v;
    sample_req = 1'b1;
    step();
    sample_req = 1'b0;
    volume = v_after;
    check({tag, " valid@1"}, sample_valid, 0);
    step();
    check({tag, " valid@2"}, sample_valid, 0);
    step();
    check({tag, " valid@3"}, sample_valid, 1);
    check({tag, " sample"}, sample, e);
    step();
    check({tag, " valid@4"}, sample_valid, 0);
    check({tag, " hold"}, sample, e);
    repeat (4) step();
  endtask

  initial begin
    int first;
    int last;
    int n;
    rst = 1'b1;
    sample_req = 1'b0;
    freq = '0;
    volume = '0;

    // reset
    repeat (2) step();
    check("rst sample", sample, 0);
    check("rst valid", sample_valid, 0);
    check("rst active", active, 0);
    sample_req = 1'b1;
    freq = 16'd16384;
    volume = 7'd127;
    step();
    sample_req = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("req under rst", sample_valid, 0);
    end
    check("rst active after", active, 0);

`ifdef TONE_ENVELOPE_EN
    // attack to volume 4, then release back to silence
    req_check("env a1", 16'd16384, 7'd4, 16'sd0, 7'd4);
    check("env active", active, 1);
    req_check("env a2", 16'd16384, 7'd4, 16'sd511, 7'd4);
    req_check("env a3", 16'd16384, 7'd4, 16'sd0, 7'd4);
    req_check("env a4", 16'd16384, 7'd4, -16'sd1024, 7'd4);
    req_check("env r3", 16'd0, 7'd4, 16'sd0, 7'd4);
    check("env release active", active, 1);
    req_check("env r2", 16'd0, 7'd4, 16'sd511, 7'd4);
    req_check("env r1", 16'd0, 7'd4, 16'sd0, 7'd4);
    req_check("env r0", 16'd0, 7'd4, 16'sd0, 7'd4);
    check("env idle active", active, 0);
`else
    // quarter-wave steps at full volume
    req_check("q0 v127", 16'd16384, 7'd127, 16'sd0, 7'd127);
    req_check("q1 v127", 16'd16384, 7'd127, 16'sd32511, 7'd127);
    check("tone active", active, 1);
    req_check("q2 v127", 16'd16384, 7'd127, 16'sd0, 7'd127);
    req_check("q3 v127", 16'd16384, 7'd127, -16'sd32512, 7'd127);

    // volume 64; volume is disturbed right after each request and must not leak in
    req_check("q0 v64", 16'd16384, 7'd64, 16'sd0, 7'd5);
    req_check("q1 v64", 16'd16384, 7'd64, 16'sd16383, 7'd5);
    req_check("q2 v64", 16'd16384, 7'd64, 16'sd0, 7'd5);
    req_check("q3 v64", 16'd16384, 7'd64, -16'sd16384, 7'd5);

    // back-to-back with wrap: phases 0, 49152, 32768, 16384, 0
    freq = 16'd49152;
    volume = 7'd127;
    exp_q.push_back(16'(0));
    exp_q.push_back(16'(-32512));
    exp_q.push_back(16'(0));
    exp_q.push_back(16'(32511));
    exp_q.push_back(16'(0));
    first = -1;
    last = -1;
    n = 0;
    sample_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 4) sample_req = 1'b0;
      if (sample_valid) begin
        if (first < 0) first = i;
        last = i;
        n++;
        if (exp_q.size() > 0) check("b2b sample", sample, $signed(exp_q.pop_front()));
      end
    end
    check("b2b pulses", n, 5);
    check("b2b first", first, 2);
    check("b2b last", last, 6);
    check("b2b leftover", exp_q.size(), 0);

    // freq 0 silences (phase 49152 would otherwise read -32767) and resets phase
    req_check("silence", 16'd0, 7'd127, 16'sd0, 7'd127);
    check("silence active", active, 0);
    req_check("restart idx0", 16'd16384, 7'd127, 16'sd0, 7'd127);
    req_check("restart idx256", 16'd16384, 7'd127, 16'sd32511, 7'd127);
    check("restart active", active, 1);
    req_check("pre-rst idx512", 16'd16384, 7'd127, 16'sd0, 7'd127);
    req_check("pre-rst idx768", 16'd16384, 7'd127, -16'sd32512, 7'd127);

    // reset one cycle after a request: it must be dropped
    sample_req = 1'b1;
    step();
    sample_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid rst sample", sample, 0);
    check("mid rst active", active, 0);
    for (int i = 0; i < 4; i++) begin
      check("mid rst valid", sample_valid, 0);
      step();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
